can_tx_mailbox_arb: RTL and testbench

//  Multi-channel CAN transmit mailbox in front of can_data_link's tx_dw1r/tx_dw2r/tx_valid/tx_ready port.

---
 rtl/can_tx_mailbox_arb.sv | 162 ++++++++++++++++
 tb/tb_can_tx_mailbox_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_mailbox_arb.sv
// Multi-channel CAN TX mailbox: per-channel frame FIFOs drained by an arbiter into one output register.
// Define CAN_TX_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module can_tx_mailbox_arb #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] ch_dw1r_in,
  input  logic [NUM_CH*DATA_W-1:0] ch_dw2r_in,
  input  logic [NUM_CH-1:0]        ch_valid_in,
  output logic [NUM_CH-1:0]        ch_ready_out,
  input  logic [NUM_CH-1:0]        ch_flush_in,
  output logic [NUM_CH*LW-1:0]     ch_level_out,
  output logic [NUM_CH-1:0]        ch_ovf_out,
  input  logic                     ovf_clr_in,
  output logic [DATA_W-1:0]        tx_dw1r_out,
  output logic [DATA_W-1:0]        tx_dw2r_out,
  output logic                     tx_valid_out,
  input  logic                     tx_ready_in,
  output logic [CW-1:0]            tx_ch_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic              init_q;
  logic [PW-1:0]     wr_q [NUM_CH];
  logic [PW-1:0]     rd_q [NUM_CH];
  logic [DATA_W-1:0] mem1_q [NUM_CH][DEPTH];
  logic [DATA_W-1:0] mem2_q [NUM_CH][DEPTH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] full, empty, push, pop, req;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_dw1_q, out_dw2_q;
  logic [CW-1:0]     out_ch_q;

  logic              load_en, grant_vld;
  logic [CW-1:0]     grant_ch;
  logic [DATA_W-1:0] sel_dw1, sel_dw2;

  always_comb begin
    ch_ready_out = '0;
    ch_level_out = '0;
    full         = '0;
    empty        = '0;
    push         = '0;
    req          = '0;
    ovf_d        = ovf_q & ~{NUM_CH{ovf_clr_in}};
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      full[c]  = (wr_q[c][AW] != rd_q[c][AW]) && (wr_q[c][AW-1:0] == rd_q[c][AW-1:0]);
      empty[c] = (wr_q[c] == rd_q[c]);
      ch_level_out[c*LW +: LW] = LW'(wr_q[c] - rd_q[c]);
      // init_q keeps ready low until the first cycle out of reset
      ch_ready_out[c] = init_q & ~full[c] & ~ch_flush_in[c];
      push[c] = ch_valid_in[c] & ch_ready_out[c];
      req[c]  = ~empty[c] & ~ch_flush_in[c];
      if (ch_valid_in[c] && full[c] && !ch_flush_in[c]) ovf_d[c] = 1'b1;
    end
  end

`ifdef CAN_TX_RR_EN
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  always_comb begin
    load_en   = ~out_valid_q | tx_ready_in;
    grant_vld = 1'b0;
    grant_ch  = '0;
`ifdef CAN_TX_RR_EN
    // rr_ptr_q holds the channel after the last grant, i.e. where the search begins
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      logic [CW-1:0] cand;
      cand = CW'((32'(rr_ptr_q) + k) % NUM_CH);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (load_en && grant_vld)
      rr_ptr_d = (32'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + CW'(1);
`else
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!grant_vld && req[c]) begin
        grant_vld = 1'b1;
        grant_ch  = CW'(c);
      end
    end
`endif
    sel_dw1 = '0;
    sel_dw2 = '0;
    pop     = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant_vld && grant_ch == CW'(c)) begin
        sel_dw1 = mem1_q[c][rd_q[c][AW-1:0]];
        sel_dw2 = mem2_q[c][rd_q[c][AW-1:0]];
        pop[c]  = load_en;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem1_q[c][wr_q[c][AW-1:0]] <= ch_dw1r_in[c*DATA_W +: DATA_W];
        mem2_q[c][wr_q[c][AW-1:0]] <= ch_dw2r_in[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      init_q      <= 1'b0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_dw1_q   <= '0;
      out_dw2_q   <= '0;
      out_ch_q    <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_q[c] <= '0;
        rd_q[c] <= '0;
      end
    end else begin
      init_q <= 1'b1;
      ovf_q  <= ovf_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_flush_in[c]) begin
          rd_q[c] <= wr_q[c];
        end else begin
          if (push[c]) wr_q[c] <= wr_q[c] + PW'(1);
          if (pop[c])  rd_q[c] <= rd_q[c] + PW'(1);
        end
      end
      if (load_en) begin
        out_valid_q <= grant_vld;
        if (grant_vld) begin
          out_dw1_q <= sel_dw1;
          out_dw2_q <= sel_dw2;
          out_ch_q  <= grant_ch;
        end
      end
    end
  end

`ifdef CAN_TX_RR_EN
  always_ff @(posedge sys_clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign ch_ovf_out   = ovf_q;
  assign tx_valid_out = out_valid_q;
  assign tx_dw1r_out  = out_dw1_q;
  assign tx_dw2r_out  = out_dw2_q;
  assign tx_ch_out    = out_ch_q;

endmodule

// File: tb/tb_can_tx_mailbox_arb.sv
// Bench for can_tx_mailbox_arb: directed vector table, corner-case sequences, and randomized
// traffic against a queue-based reference model with a per-channel scoreboard.
module tb_can_tx_mailbox_arb;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
  } frame_t;

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] dw1;
    logic [DATA_W-1:0] dw2;
    logic [LW-1:0]     exp_lvl;
    logic              exp_valid;
    logic [CW-1:0]     exp_ch;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH*DATA_W-1:0] dw1_in, dw2_in;
  logic [NUM_CH-1:0]        valid_in, ready_o, flush_in, ovf_o;
  logic [NUM_CH*LW-1:0]     level_o;
  logic                     ovf_clr;
  logic [DATA_W-1:0]        tx_dw1, tx_dw2;
  logic                     tx_valid, tx_ready;
  logic [CW-1:0]            tx_ch;

  int n_checks = 0;
  int n_err    = 0;

  can_tx_mailbox_arb #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .sys_clk(clk), .reset(rst),
    .ch_dw1r_in(dw1_in), .ch_dw2r_in(dw2_in),
    .ch_valid_in(valid_in), .ch_ready_out(ready_o), .ch_flush_in(flush_in),
    .ch_level_out(level_o), .ch_ovf_out(ovf_o), .ovf_clr_in(ovf_clr),
    .tx_dw1r_out(tx_dw1), .tx_dw2r_out(tx_dw2), .tx_valid_out(tx_valid),
    .tx_ready_in(tx_ready), .tx_ch_out(tx_ch)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel plus the output-stage frame.
  frame_t            mq [NUM_CH][$];
  frame_t            sb [NUM_CH][$];
  logic              m_out_v;
  frame_t            m_out;
  int                m_out_ch;
  logic [NUM_CH-1:0] m_ovf;
  logic              m_init;
`ifdef CAN_TX_RR_EN
  int                m_rr;
`endif
  vec_t              tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] lvl(input int c);
    return level_o[c*LW +: LW];
  endfunction

  function automatic frame_t inc_frame(input int k);
    frame_t f;
    int i;
    i = k * 8;
    f.d1 = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
    f.d2 = {8'(i + 4), 8'(i + 5), 8'(i + 6), 8'(i + 7)};
    return f;
  endfunction

  task automatic model_step();
    int sz [NUM_CH];
    int g;
    frame_t f;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_out_v = 1'b0; m_out = '0; m_out_ch = 0; m_ovf = '0; m_init = 1'b0;
`ifdef CAN_TX_RR_EN
      m_rr = 0;
`endif
      return;
    end
    for (int c = 0; c < NUM_CH; c++) sz[c] = mq[c].size();
    g = -1;
`ifdef CAN_TX_RR_EN
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_rr + k) % NUM_CH;
      if (g < 0 && sz[c] > 0 && !flush_in[c]) g = c;
    end
`else
    for (int c = 0; c < NUM_CH; c++)
      if (g < 0 && sz[c] > 0 && !flush_in[c]) g = c;
`endif
    if (!m_out_v || tx_ready) begin
      if (g >= 0) begin
        m_out = mq[g].pop_front(); m_out_ch = g; m_out_v = 1'b1;
`ifdef CAN_TX_RR_EN
        m_rr = (g + 1) % NUM_CH;
`endif
      end else begin
        m_out_v = 1'b0;
      end
    end
    if (ovf_clr) m_ovf = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      f.d1 = dw1_in[c*DATA_W +: DATA_W];
      f.d2 = dw2_in[c*DATA_W +: DATA_W];
      if (flush_in[c]) mq[c].delete();
      else if (valid_in[c] && m_init) begin
        if (sz[c] < DEPTH) mq[c].push_back(f);
        else m_ovf[c] = 1'b1;
      end
    end
    m_init = 1'b1;
  endtask

  task automatic compare_all();
    chk("tx_valid", tx_valid, m_out_v);
    if (m_out_v) begin
      chk("tx_dw1r", tx_dw1, m_out.d1);
      chk("tx_dw2r", tx_dw2, m_out.d2);
      chk("tx_ch", tx_ch, m_out_ch);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("ready[%0d]", c), ready_o[c], m_init && (mq[c].size() < DEPTH) && !flush_in[c]);
      chk($sformatf("level[%0d]", c), lvl(c), mq[c].size());
      chk($sformatf("ovf[%0d]", c), ovf_o[c], m_ovf[c]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic put(input int c, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    valid_in[c] = 1'b1;
    dw1_in[c*DATA_W +: DATA_W] = a;
    dw2_in[c*DATA_W +: DATA_W] = b;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seen, saw9, acc, cnt, k, delivered, c;
    int got[$];
    int exp_ord [6];
    frame_t f;

    tbl[0] = '{0, 32'h00010203, 32'h04050607, 4'd1, 1'b1, 2'd0};
    tbl[1] = '{1, 32'hDEADBEEF, 32'h01234567, 4'd1, 1'b1, 2'd1};
    tbl[2] = '{2, 32'hFFFFFFFF, 32'h00000000, 4'd1, 1'b1, 2'd2};
    tbl[3] = '{3, 32'h00000000, 32'hFFFFFFFF, 4'd1, 1'b1, 2'd3};
    tbl[4] = '{3, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'd1, 1'b1, 2'd3};
    tbl[5] = '{0, 32'h80000001, 32'h7FFFFFFE, 4'd1, 1'b1, 2'd0};
`ifdef CAN_TX_RR_EN
    exp_ord = '{0, 2, 0, 2, 0, 2};
`else
    exp_ord = '{0, 0, 0, 2, 2, 2};
`endif

    rst = 1'b1; valid_in = '0; flush_in = '0; dw1_in = '0; dw2_in = '0;
    tx_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) step();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_dw1", tx_dw1, 0);
    chk("rst_dw2", tx_dw2, 0);
    chk("rst_ch", tx_ch, 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", ready_o, {NUM_CH{1'b1}});

    // Single frames through an idle system, one-cycle latency
    tx_ready = 1'b1;
    foreach (tbl[i]) begin
      put(tbl[i].ch, tbl[i].dw1, tbl[i].dw2);
      step();
      valid_in = '0;
      chk("tbl_level", lvl(tbl[i].ch), tbl[i].exp_lvl);
      step();
      chk("tbl_valid", tx_valid, tbl[i].exp_valid);
      chk("tbl_dw1", tx_dw1, tbl[i].dw1);
      chk("tbl_dw2", tx_dw2, tbl[i].dw2);
      chk("tbl_ch", tx_ch, tbl[i].exp_ch);
      step();
      chk("tbl_drained", tx_valid, 0);
    end

    // Overflow on ch1 with the output stage blocked
    tx_ready = 1'b0;
    put(1, 32'hB10C0000, 32'hB10C0001);
    step();
    valid_in = '0;
    step();
    chk("blocker_loaded", tx_dw1, 32'hB10C0000);
    for (int n = 1; n <= DEPTH + 1; n++) begin
      put(1, 32'h11000000 + n, 32'h22000000 + n);
      ovf_clr = (n == DEPTH + 1);
      step();
      if (n == DEPTH) begin
        chk("full_ready1", ready_o[1], 0);
        chk("full_level1", lvl(1), DEPTH);
        chk("full_ovf_clear", ovf_o[1], 0);
      end
    end
    valid_in = '0; ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf_o, 4'b0010);
    chk("ovf_level1", lvl(1), DEPTH);
    tx_ready = 1'b1;
    seen = 0; saw9 = 0;
    for (int n = 0; n < 20; n++) begin
      if (tx_valid) begin
        seen++;
        if (tx_dw1 == 32'h11000000 + DEPTH + 1) saw9 = 1;
      end
      step();
    end
    chk("ovf_drain_count", seen, DEPTH + 1);
    chk("frame9_absent", saw9, 0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf_o, 0);

    // Arbitration order between ch0 and ch2
    rst = 1'b1; step(); rst = 1'b0; step();
    tx_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      put(0, 32'hA0000000 + n, 32'hA1000000 + n);
      put(2, 32'hC0000000 + n, 32'hC1000000 + n);
      step();
    end
    valid_in = '0;
    tx_ready = 1'b1;
    for (int n = 0; n < 12 && got.size() < 6; n++) begin
      if (tx_valid) got.push_back(int'(tx_ch));
      step();
    end
    chk("order_count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk($sformatf("order[%0d]", i), got[i], exp_ord[i]);

    // Backpressure hold for 20 cycles, then exactly one acceptance
    tx_ready = 1'b0;
    put(1, 32'h44444444, 32'h55555555);
    step();
    valid_in = '0;
    step();
    for (int n = 0; n < 20; n++) begin
      step();
      chk("hold_valid", tx_valid, 1);
      chk("hold_frame", {tx_dw1, tx_dw2, 30'd0, tx_ch}, {32'h44444444, 32'h55555555, 30'd0, 2'd1});
    end
    tx_ready = 1'b1;
    acc = 0;
    for (int n = 0; n < 5; n++) begin
      if (tx_valid && tx_ready) acc++;
      step();
    end
    chk("accept_once", acc, 1);

    // Flush of a full ch3 with a coincident write
    tx_ready = 1'b0;
    for (int n = 0; n < DEPTH + 1; n++) begin
      put(3, 32'h33000000 + n, 32'h3F000000 + n);
      step();
    end
    valid_in = '0;
    chk("preflush_level3", lvl(3), DEPTH);
    put(3, 32'h3DEAD000, 32'h3DEAD001);
    flush_in[3] = 1'b1;
    step();
    valid_in = '0; flush_in = '0;
    chk("flush_level3", lvl(3), 0);
    chk("flush_no_ovf", ovf_o[3], 0);
    chk("flush_out_kept", tx_dw1, 32'h33000000);
    tx_ready = 1'b1;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      if (tx_valid) cnt++;
      step();
    end
    chk("flush_sent_once", cnt, 1);

    // Randomized traffic: 128 incrementing frames on random channels
    k = 0; delivered = 0;
    for (int cyc = 0; cyc < 4000 && (k < 128 || delivered < 128); cyc++) begin
      valid_in = '0;
      if (k < 128 && $urandom_range(0, 3) != 0) begin
        c = $urandom_range(0, NUM_CH - 1);
        if (mq[c].size() < DEPTH) begin
          f = inc_frame(k);
          put(c, f.d1, f.d2);
          sb[c].push_back(f);
          k++;
        end
      end
      tx_ready = (k < 128) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (tx_valid && tx_ready) begin
        delivered++;
        c = int'(tx_ch);
        chk("sb_has_frame", sb[c].size() != 0, 1);
        if (sb[c].size() != 0) chk("sb_frame", {tx_dw1, tx_dw2}, sb[c].pop_front());
      end
      step();
    end
    valid_in = '0;
    chk("rand_pushed", k, 128);
    chk("rand_delivered", delivered, 128);
    for (int i = 0; i < NUM_CH; i++) chk($sformatf("sb_empty[%0d]", i), sb[i].size(), 0);

    // Reset while a frame is waiting on the link
    tx_ready = 1'b0;
    put(2, 32'h77777777, 32'h88888888);
    step();
    valid_in = '0;
    step();
    chk("mid_valid_before", tx_valid, 1);
    rst = 1'b1;
    step();
    chk("mid_valid_dropped", tx_valid, 0);
    chk("mid_ready_low", ready_o, 0);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
